// File: rtl/clm_rand_feeder.sv
// Randomness distribution unit: buffers fresh random sets in a FIFO and hands every
// S-box channel a rotated copy of the current set, with bounded rotated reuse when starved.
module clm_rand_feeder #(
  parameter int D         = 8,
  parameter int NVEC      = 7,
  parameter int NCH       = 4,
  parameter int DEPTH     = 4,
  parameter int REUSE_MAX = 2,
  localparam int RW       = (REUSE_MAX > 0) ? $clog2(REUSE_MAX + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [D*NVEC-1:0]     rnd_in,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  logic                  load_r,
  output logic [NCH*NVEC*D-1:0] r_out,
  output logic                  r_valid,
  output logic                  fresh,
  output logic                  stall,
  output logic [RW-1:0]         reuse_cnt
);

  localparam int SW   = D * NVEC;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int ROTW = $clog2(NVEC);

  typedef enum logic [1:0] {EMPTY, ACTIVE, STARVED} state_t;

  state_t          state;
  logic [SW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   cur;
  logic [ROTW-1:0] rot;

  logic push;
  logic pop;
  logic avail;
  logic reuse_ok;

  // A set pushed this cycle is not yet counted, so it cannot satisfy a same-cycle load.
  assign rnd_ready = !rst && (count < CW'(DEPTH));
  assign push      = rnd_valid && rnd_ready;
  assign avail     = (count != '0);
  assign reuse_ok  = (int'(reuse_cnt) < REUSE_MAX);
  assign pop       = avail && ((state != ACTIVE) || load_r);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rnd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur       <= '0;
      rot       <= '0;
      reuse_cnt <= '0;
      fresh     <= 1'b0;
      r_valid   <= 1'b0;
      stall     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (pop) begin
        cur       <= mem[rd_ptr];
        rot       <= '0;
        reuse_cnt <= '0;
        fresh     <= 1'b1;
        r_valid   <= 1'b1;
        stall     <= 1'b0;
        state     <= ACTIVE;
      end else if (state == ACTIVE && load_r) begin
        if (reuse_ok) begin
          rot       <= (rot == ROTW'(NVEC - 1)) ? '0 : rot + 1'b1;
          reuse_cnt <= reuse_cnt + 1'b1;
          fresh     <= 1'b0;
        end else begin
          r_valid <= 1'b0;
          stall   <= 1'b1;
          state   <= STARVED;
        end
      end
    end
  end

  // Channel c sees the set rotated by c on top of the reuse rotation.
  always_comb begin
    r_out = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < NVEC; i++) begin
        r_out[(c*NVEC + i)*D +: D] = cur[((i + c + int'(rot)) % NVEC)*D +: D];
      end
    end
  end

endmodule

// File: doc/clm_rand_feeder.md
# clm_rand_feeder

Parametrised randomness distribution unit for the CLM masked-AES datapath. It sits between the external fresh-randomness source and the Sub-Bytes / key-expansion S-box channels, and buffers incoming words of `NVEC` reduction-polynomial vectors in a FIFO. It supplies every channel with a per-channel rotated copy of the current random set, generalising the fixed 7-vector `shift_randomness` rotation. When the source falls behind, a bounded reuse mode re-rotates the current set, and the unit stalls the consumer once the reuse budget is spent.

## Interface
- `D`, 8: redundancy degree; width of one random vector (matches `types::d`).
- `NVEC`, 7: random vectors per set; must be ≥2.
- `NCH`, 4: S-box channels fed (4 or 16 per `CHEAP_SB`); must be ≥1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `REUSE_MAX`, 2: rotated reuses allowed per fresh set; 0 disables reuse.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rnd_in`  in  D*NVEC  fresh random set; vector i at `[i*D +: D]`.
- `rnd_valid`  in  1  `rnd_in` is valid.
- `rnd_ready`  out  1  the unit can accept a set.
- `load_r`  in  1  single-cycle pulse requesting a new random set for the consumer.
- `r_out`  out  NCH*NVEC*D  channel c vector i at `[(c*NVEC+i)*D +: D]`.
- `r_valid`  out  1  `r_out` holds usable randomness.
- `fresh`  out  1  the current set has not been reused.
- `stall`  out  1  reuse budget exhausted and no fresh data is available.
- `reuse_cnt`  out  $clog2(REUSE_MAX+1) (min 1)  reuses of the current set.

## Operation
- Storage: `cur` register (NVEC×D), rotation counter `rot` (0..NVEC-1), FIFO with wrap-around read and write pointers, and an occupancy `count` (0..DEPTH).
- Push: a set is pushed when `rnd_valid && rnd_ready`. `rnd_ready` = `!rst && count<DEPTH`. There is no push-through when the FIFO is full, even if a pop occurs in the same cycle.
- Output mapping, combinational from registers: `r_out[c][i] = cur[(i + c + rot) mod NVEC]`.
- A fresh load does the following: `cur` ← FIFO head, pop, `rot` ← 0, `reuse_cnt` ← 0, `fresh` ← 1, `r_valid` ← 1, `stall` ← 0.
- FSM states are EMPTY, ACTIVE and STARVED.
  - EMPTY is the reset state. When `count>0`, do a fresh load and go to ACTIVE. `load_r` is ignored in EMPTY.
  - ACTIVE, on `load_r`:
    - If `count>0`: fresh load.
    - Else if `reuse_cnt<REUSE_MAX`: `rot` ← (rot+1) mod NVEC, `reuse_cnt`+1, `fresh` ← 0.
    - Else: `r_valid` ← 0, `stall` ← 1, go to STARVED.
  - ACTIVE without `load_r`: hold.
  - STARVED: when `count>0`, do a fresh load and go to ACTIVE. This load satisfies the pending request. Further `load_r` pulses in STARVED are ignored.
- Simultaneous push and `load_r` with `count==0`: the pushed set is not yet visible, so the reuse or starve path is taken. The new set is served on the next load.
- Simultaneous push and pop: `count` is unchanged.

## Timing
- Reset values: `r_valid`=0, `fresh`=0, `stall`=0, `reuse_cnt`=0, `r_out`=0 (`cur` cleared), `rnd_ready`=0 while `rst` is high, FIFO flushed, state EMPTY.
- Reset asserted mid-operation discards all buffered sets. `rnd_ready` returns to 1 in the first cycle after `rst` deasserts.
- Push latency into an idle unit: push sampled at edge k, entry counted after edge k, fresh load at edge k+1. `r_valid`=1 from edge k+1, i.e. two cycles after the cycle in which `rnd_valid` is presented.
- `load_r` served from the FIFO or by reuse: `r_out` and flags update at the edge that samples `load_r`, so they are valid the following cycle.
- Wrap-around:
  - `rot` wraps from NVEC-1 to 0.
  - FIFO pointers wrap modulo DEPTH.
  - `count` never exceeds DEPTH.

## Test plan
All scenarios use D=8, NVEC=7, NCH=4, DEPTH=4, REUSE_MAX=2. Set Wn has vector i = 0xN0+i (e.g. W1 vector i = 0x10+i).

- Initial load: reset, then push W1 → two cycles later `r_valid`=1, `fresh`=1, ch0 v0=0x10, ch1 v0=0x11, ch3 v6=0x12 (index (6+3) mod 7 = 2).
- Fill: push W1..W6 back-to-back with no `load_r` → W1 goes to `cur`, W2..W5 are accepted, `rnd_ready`=0 while W6 is held. One `load_r` → `cur`=W2, and W6 is accepted the next cycle.
- Reuse and starve: FIFO empty, `cur`=W1.
  - First `load_r` → ch0 v0=0x11, `reuse_cnt`=1, `fresh`=0.
  - Second `load_r` → ch0 v0=0x12, `reuse_cnt`=2.
  - Third `load_r` → `r_valid`=0, `stall`=1.
  - Push W2 → two cycles later `r_valid`=1, `stall`=0, `fresh`=1, ch0 v0=0x20.
- Simultaneous push and `load_r` on an empty FIFO with `cur`=W1 → reuse path (ch0 v0=0x11). The next `load_r` yields W2 with `fresh`=1.
- Rotation wrap: REUSE_MAX overridden to 8, 7 reuses of W1 → ch0 v0 returns to 0x10 and `rot`=0.
- Mid-operation reset: 3 sets buffered, pulse `rst` for one cycle → all outputs at reset values. The next pushed W7 appears as ch0 v0=0x70, and no stale set appears.
